// File: rtl/sw_input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// sw_input_conditioner_pkg
// Shared defaults, types and helpers for the slide-switch input conditioner.
//   DEBOUNCE_CYCLES_DEFAULT : stability window in clk cycles (10 ms @ 50 MHz)
//   SYNC_STAGES_DEFAULT     : synchronizer flop depth
//   sw_vec_t                : 8-bit switch vector
//   cnt_width()             : debounce counter width for a given window
// ---------------------------------------------------------------------------
package sw_input_conditioner_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
  localparam int unsigned SW_WIDTH_DEFAULT        = 8;

  typedef logic [SW_WIDTH_DEFAULT-1:0] sw_vec_t;

  // Counter only has to reach cycles-1, so clog2(cycles) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_input_conditioner_debounce_bit.sv
// ---------------------------------------------------------------------------
// sw_debounce_bit
// One switch bit: SYNC_STAGES-deep synchronizer, stability counter and the
// debounced output flop.
// Ports:
//   clk     : system clock
//   reset   : asynchronous, active-high reset
//   raw     : asynchronous switch pin
//   stable  : debounced level
//   commit  : high in the cycle whose closing edge updates `stable`
// ---------------------------------------------------------------------------
module sw_debounce_bit
  import sw_input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic commit
);

  localparam int unsigned     CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Driven only from flops, so the top-level pulse has no input-to-output path.
  assign commit = (s != stable) && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      stable <= 1'b0;
    end else if (s == stable) begin
      cnt_q <= '0;
    end else if (commit) begin
      stable <= s;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sw_input_conditioner.sv
// ---------------------------------------------------------------------------
// sw_input_conditioner
// Synchronizes and debounces the board slide switches before the PIO in_port.
// Ports:
//   clk          : system clock
//   reset        : asynchronous, active-high reset
//   sw_raw       : asynchronous switch pins
//   sw_stable    : debounced vector (drives PIO in_port)
//   changed      : one-cycle pulse, coincident with any sw_stable update
//   edge_capture : sticky rising-edge flags
//   edge_clear   : write-one-to-clear for edge_capture
// Build option: SW_INPUT_CONDITIONER_EDGE_CAPTURE_EN enables the edge-capture
// flops; otherwise edge_capture reads 0 and edge_clear is ignored.
// ---------------------------------------------------------------------------
module sw_input_conditioner
  import sw_input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             changed,
  output logic [WIDTH-1:0] edge_capture,
  input  logic [WIDTH-1:0] edge_clear
);

  logic [WIDTH-1:0] commit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i]),
      .commit (commit[i])
    );
  end

  // Registered on the commit edge, so it lines up with the new sw_stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      changed <= 1'b0;
    end else begin
      changed <= |commit;
    end
  end

`ifdef SW_INPUT_CONDITIONER_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_q;

  // Rise is detected against the delayed copy, so the flag sets one cycle
  // after `changed`; OR-ing the set last makes set win over a same-edge clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d <= '0;
      edge_q   <= '0;
    end else begin
      stable_d <= sw_stable;
      edge_q   <= (edge_q & ~edge_clear) | (sw_stable & ~stable_d);
    end
  end

  assign edge_capture = edge_q;
`else
  logic unused_edge_clear;
  assign unused_edge_clear = ^edge_clear;
  assign edge_capture      = '0;
`endif

endmodule
